uart_mem_server: RTL and testbench

- Memory responder at the far end of the UART memory link; the counterpart of the CPU-side memory controller that issues read/write requests over UART.
- Pops request packets from a byte-level UART receive FIFO, services them from a local byte-addressed RAM, and pushes reply bytes to the UART transmit side.
- Used as the host/memory model in simulation, and as an FPGA-side loopback memory server for link bring-up.

---
 rtl/uart_mem_server.sv | 162 ++++++++++++++++
 tb/tb_uart_mem_server.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_server.sv
// rtl/uart_mem_server.sv - UART-side memory responder: parses read/write packets, serves a local byte RAM
module uart_mem_server #(
  parameter int          MEM_AW     = 16,
  parameter int          ADDR_BYTES = 4,
  parameter int          TIMEOUT    = 100000,
  parameter logic [7:0]  ACK_BYTE   = 8'hA5,
  parameter logic [7:0]  ERR_BYTE   = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  recv_data,
  input  logic        recv_avail,
  output logic        recv_re,
  output logic [7:0]  send_data,
  output logic        send_en,
  input  logic        send_avail,
  output logic        busy,
  output logic [15:0] req_cnt,
  output logic [7:0]  err_cnt
);

  localparam int                AW_FULL   = ADDR_BYTES * 8;
  localparam int                TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]        ADDR_LAST = 8'(ADDR_BYTES - 1);
  localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]     TO_ONE    = 1;
  localparam logic [MEM_AW-1:0] A_ONE     = 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WACK, S_RDATA, S_ERR} state_t;

  state_t              r_state, w_next;
  logic [7:0]          r_mem [0:(1<<MEM_AW)-1];
  logic [7:0]          r_rdata;
  logic                r_is_wr;
  logic [1:0]          r_len;
  logic [AW_FULL-1:0]  r_addr;
  logic [7:0]          r_cnt;
  logic [TW-1:0]       r_to;
  logic                r_rx_ok, r_tx_ok, r_rd_ok, r_busy;
  logic [15:0]         r_req_cnt;
  logic [7:0]          r_err_cnt;

  logic                w_want_rx, w_want_tx, w_pop, w_send, w_timeout, w_err_inc;
  logic [7:0]          w_len_last, w_send_data;
  logic [MEM_AW-1:0]   w_maddr;

  assign w_maddr   = r_addr[MEM_AW-1:0];
  assign w_want_rx = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
  assign w_want_tx = (r_state == S_WACK) || (r_state == S_ERR) || ((r_state == S_RDATA) && r_rd_ok);
  // r_rx_ok / r_tx_ok enforce a gap cycle after every strobe and are low during reset
  assign w_pop     = w_want_rx && recv_avail && r_rx_ok;
  assign w_send    = w_want_tx && send_avail && r_tx_ok;
  assign w_timeout = ((r_state == S_ADDR) || (r_state == S_WDATA)) && !w_pop && (r_to == TO_LAST);
  assign w_err_inc = w_timeout || ((r_state == S_ERR) && w_send);

  assign recv_re   = w_pop;
  assign send_en   = w_send;
  assign send_data = w_send_data;
  assign busy      = r_busy;
  assign req_cnt   = r_req_cnt;
  assign err_cnt   = r_err_cnt;

  always_comb begin
    w_len_last = 8'd3;
    case (r_len)
      2'd0:    w_len_last = 8'd0;
      2'd1:    w_len_last = 8'd1;
      default: w_len_last = 8'd3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_send_data = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (w_pop) w_next = (recv_data[1:0] == 2'b11) ? S_ERR : S_ADDR;
      end
      S_ADDR: begin
        if (w_pop && (r_cnt == ADDR_LAST)) w_next = r_is_wr ? S_WDATA : S_RDATA;
        else if (w_timeout)                w_next = S_IDLE;
      end
      S_WDATA: begin
        if (w_pop && (r_cnt == w_len_last)) w_next = S_WACK;
        else if (w_timeout)                 w_next = S_IDLE;
      end
      S_WACK: begin
        w_send_data = ACK_BYTE;
        if (w_send) w_next = S_IDLE;
      end
      S_RDATA: begin
        w_send_data = r_rdata;
        if (w_send && (r_cnt == w_len_last)) w_next = S_IDLE;
      end
      S_ERR: begin
        w_send_data = ERR_BYTE;
        if (w_send) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_wr   <= 1'b0;
      r_len     <= 2'd0;
      r_addr    <= '0;
      r_cnt     <= 8'd0;
      r_to      <= '0;
      r_rx_ok   <= 1'b0;
      r_tx_ok   <= 1'b0;
      r_rd_ok   <= 1'b0;
      r_busy    <= 1'b0;
      r_req_cnt <= 16'd0;
      r_err_cnt <= 8'd0;
    end else begin
      r_rx_ok <= !w_pop;
      r_tx_ok <= !w_send;
      r_busy  <= (w_next != S_IDLE);
      // r_rdata tracks r_addr one cycle late, so data is only trusted after a settled cycle
      r_rd_ok <= (r_state == S_RDATA) && !w_send;
      if (((r_state == S_ADDR) || (r_state == S_WDATA)) && !w_pop && !w_timeout)
        r_to <= r_to + TO_ONE;
      else
        r_to <= '0;
      case (r_state)
        S_IDLE: if (w_pop) begin
          r_is_wr <= recv_data[7];
          r_len   <= recv_data[1:0];
          r_cnt   <= 8'd0;
        end
        S_ADDR: if (w_pop) begin
          r_addr <= {recv_data, r_addr[AW_FULL-1:8]};
          r_cnt  <= (r_cnt == ADDR_LAST) ? 8'd0 : r_cnt + 8'd1;
        end
        S_WDATA: if (w_pop) begin
          r_addr[MEM_AW-1:0] <= w_maddr + A_ONE;
          r_cnt              <= r_cnt + 8'd1;
        end
        S_WACK: if (w_send) r_req_cnt <= r_req_cnt + 16'd1;
        S_RDATA: if (w_send) begin
          r_addr[MEM_AW-1:0] <= w_maddr + A_ONE;
          r_cnt              <= r_cnt + 8'd1;
          if (r_cnt == w_len_last) r_req_cnt <= r_req_cnt + 16'd1;
        end
        default: ;
      endcase
      if (w_err_inc && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_WDATA) && w_pop) r_mem[w_maddr] <= recv_data;
    r_rdata <= r_mem[w_maddr];
  end

endmodule

// File: tb/tb_uart_mem_server.sv
// tb/tb_uart_mem_server.sv - self-checking bench for uart_mem_server with a packet-level host model
module tb_uart_mem_server;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  recv_data = 8'h00;
  logic        recv_avail = 1'b0;
  logic        recv_re;
  logic [7:0]  send_data;
  logic        send_en;
  logic        send_avail;
  logic        busy;
  logic [15:0] req_cnt;
  logic [7:0]  err_cnt;

  uart_mem_server #(.MEM_AW(16), .ADDR_BYTES(4), .TIMEOUT(50), .ACK_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rst(rst), .recv_data(recv_data), .recv_avail(recv_avail), .recv_re(recv_re),
    .send_data(send_data), .send_en(send_en), .send_avail(send_avail), .busy(busy),
    .req_cnt(req_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] rx_q[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         rx_toggle = 1'b0;
  bit         tx_gate = 1'b1;
  int         cyc = 0;
  int         viol = 0;
  bit         prev_re = 1'b0, prev_en = 1'b0;
  logic [7:0] m_mem [0:65535];
  bit         m_val [0:65535];
  int         m_req = 0, m_err = 0;
  int         n_tests = 0, n_fail = 0;

  assign send_avail = tx_gate;

  // host FIFO and reply capture; protocol violations are tallied for the tests to inspect
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (recv_re && rx_q.size() > 0) void'(rx_q.pop_front());
    if (send_en) got_q.push_back(send_data);
    viol <= viol + int'(send_en && !send_avail) + int'(send_en && prev_en)
                 + int'(recv_re && prev_re) + int'(recv_re && !recv_avail);
    prev_en <= send_en;
    prev_re <= recv_re;
  end

  always @(negedge clk) begin
    recv_avail = (rx_q.size() > 0) && (!rx_toggle || ((cyc / 3) % 2 == 0));
    recv_data  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  function automatic int idx(input logic [31:0] a, input int i);
    logic [31:0] t;
    t = a + i;
    return int'(t % 65536);
  endfunction

  task automatic push_pkt(input bit wr, input logic [1:0] lc, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] junk = 5'd0);
    int len;
    len = 1 << lc;
    rx_q.push_back({wr, junk, lc});
    for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
    if (wr) begin
      for (int i = 0; i < len; i++) begin
        rx_q.push_back(d[8*i +: 8]);
        m_mem[idx(a, i)] = d[8*i +: 8];
        m_val[idx(a, i)] = 1'b1;
      end
      exp_q.push_back(8'hA5);
    end else begin
      for (int i = 0; i < len; i++) exp_q.push_back(m_mem[idx(a, i)]);
    end
    m_req++;
  endtask

  task automatic push_bad();
    logic [7:0] c;
    c = 8'($urandom());
    c[1:0] = 2'b11;
    rx_q.push_back(c);
    exp_q.push_back(8'hEE);
    if (m_err < 255) m_err++;
  endtask

  task automatic wait_done(input int lim, output bit ok);
    int k;
    k = 0;
    while (k < lim && !(rx_q.size() == 0 && !busy && got_q.size() >= exp_q.size())) begin
      @(negedge clk);
      k++;
    end
    ok = (k < lim);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_q.push_back(8'h00);
    repeat (3) @(negedge clk);
    n_tests++; if (recv_re !== 1'b0)    begin n_fail++; $display("FAIL reset_recv_re got %b want 0", recv_re); end
    n_tests++; if (send_en !== 1'b0)    begin n_fail++; $display("FAIL reset_send_en got %b want 0", send_en); end
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL reset_send_data got %h want 00", send_data); end
    n_tests++; if (req_cnt !== 16'h0)   begin n_fail++; $display("FAIL reset_req_cnt got %0d want 0", req_cnt); end
    n_tests++; if (err_cnt !== 8'h0)    begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    rx_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    bit ok;
    push_pkt(1'b1, 2'd2, 32'h0000_0010, 32'h4433_2211);
    wait_done(2000, ok);
    n_tests++;
    if (!ok || got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      n_fail++; $display("FAIL wr_ack got %0d bytes first %h want 1 byte a5", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00);
    end
    n_tests++; if (req_cnt !== 16'd1) begin n_fail++; $display("FAIL wr_req_cnt got %0d want 1", req_cnt); end
    got_q.delete(); exp_q.delete();
    push_pkt(1'b0, 2'd2, 32'h0000_0010, 32'h0);
    wait_done(2000, ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rd4_len got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rd4_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (req_cnt !== 16'd2) begin n_fail++; $display("FAIL rd_req_cnt got %0d want 2", req_cnt); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_wrap();
    bit ok;
    push_pkt(1'b1, 2'd1, 32'h0001_FFFF, 32'h0000_CDAB);
    push_pkt(1'b0, 2'd1, 32'h0000_FFFF, 32'h0);
    push_pkt(1'b0, 2'd0, 32'h0000_0000, 32'h0);
    wait_done(3000, ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL wrap_len got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL wrap_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    bit ok;
    rx_q.push_back(8'h03);
    exp_q.push_back(8'hEE);
    m_err++;
    rx_q.push_back(8'h00);
    for (int i = 0; i < 4; i++) rx_q.push_back(i == 0 ? 8'h10 : 8'h00);
    exp_q.push_back(m_mem[16'h0010]);
    m_req++;
    wait_done(2000, ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL illegal_len got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL illegal_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (err_cnt !== 8'(m_err)) begin n_fail++; $display("FAIL illegal_err_cnt got %0d want %0d", err_cnt, m_err); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flow();
    bit ok;
    int k, held;
    rx_toggle = 1'b1;
    push_pkt(1'b0, 2'd0, 32'h0000_0012, 32'h0);
    push_pkt(1'b0, 2'd2, 32'h0000_0010, 32'h0);
    k = 0;
    while (k < 2000 && got_q.size() < 2) begin @(negedge clk); k++; end
    tx_gate = 1'b0;
    held = got_q.size();
    repeat (20) @(negedge clk);
    n_tests++; if (got_q.size() != held) begin n_fail++; $display("FAIL flow_stall got %0d bytes want %0d", got_q.size(), held); end
    tx_gate = 1'b1;
    wait_done(2000, ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL flow_len got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL flow_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL flow_strobes got %0d violations want 0", viol); end
    rx_toggle = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int k;
    rx_q.push_back(8'h80);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h01);
    m_err++;
    k = 0;
    while (k < 200 && rx_q.size() > 0) begin @(negedge clk); k++; end
    repeat (60) @(negedge clk);
    n_tests++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL to_busy got %b want 0", busy); end
    n_tests++; if (err_cnt !== 8'(m_err))  begin n_fail++; $display("FAIL to_err_cnt got %0d want %0d", err_cnt, m_err); end
    n_tests++; if (got_q.size() != 0)      begin n_fail++; $display("FAIL to_reply got %0d bytes want 0", got_q.size()); end
    got_q.delete();
    push_pkt(1'b0, 2'd0, 32'h0000_0010, 32'h0);
    wait_done(2000, ok);
    n_tests++;
    if (!ok || got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
      n_fail++; $display("FAIL to_next_read got %0d bytes first %h want %h", got_q.size(), got_q.size() > 0 ? got_q[0] : 8'h00, exp_q[0]);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k;
    rx_q.push_back(8'h82);
    for (int i = 0; i < 4; i++) rx_q.push_back(i == 0 ? 8'h20 : 8'h00);
    rx_q.push_back(8'hAA);
    rx_q.push_back(8'hBB);
    m_mem[16'h0020] = 8'hAA; m_val[16'h0020] = 1'b1;
    m_mem[16'h0021] = 8'hBB; m_val[16'h0021] = 1'b1;
    k = 0;
    while (k < 200 && rx_q.size() > 0) begin @(negedge clk); k++; end
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    n_tests++; if (send_en !== 1'b0 || recv_re !== 1'b0) begin n_fail++; $display("FAIL mid_rst_strobes got %b%b want 00", send_en, recv_re); end
    n_tests++; if (send_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_send_data got %h want 00", send_data); end
    n_tests++; if (req_cnt !== 16'd0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_rst_cnts got %0d/%0d want 0/0", req_cnt, err_cnt); end
    @(negedge clk);
    rst = 1'b0;
    m_req = 0; m_err = 0;
    push_pkt(1'b0, 2'd1, 32'h0000_0020, 32'h0);
    push_pkt(1'b1, 2'd2, 32'h0000_0030, $urandom());
    push_pkt(1'b0, 2'd2, 32'h0000_0030, 32'h0);
    wait_done(3000, ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL mid_len got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (req_cnt !== 16'(m_req)) begin n_fail++; $display("FAIL mid_req_cnt got %0d want %0d", req_cnt, m_req); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, d;
    int lc, wr;
    bit ok, allv;
    rx_toggle = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        push_bad();
      end else begin
        a = $urandom();
        a[15:0] = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'h0200 + 16'($urandom_range(0, 31));
        lc = $urandom_range(0, 2);
        wr = $urandom_range(0, 1);
        d = $urandom();
        allv = 1'b1;
        for (int i = 0; i < (1 << lc); i++) if (!m_val[idx(a, i)]) allv = 1'b0;
        if (!allv) wr = 1;
        push_pkt(wr[0], lc[1:0], a, d, 5'($urandom()));
      end
    end
    wait_done(20000, ok);
    n_tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_len got %0d want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      n_tests++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (req_cnt !== 16'(m_req)) begin n_fail++; $display("FAIL b2b_req_cnt got %0d want %0d", req_cnt, m_req); end
    n_tests++; if (err_cnt !== 8'(m_err))  begin n_fail++; $display("FAIL b2b_err_cnt got %0d want %0d", err_cnt, m_err); end
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL b2b_strobes got %0d violations want 0", viol); end
    rx_toggle = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin m_mem[i] = 8'h00; m_val[i] = 1'b0; end
    test_reset();
    test_write_read();
    test_wrap();
    test_illegal();
    test_flow();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
